row_packer: RTL and testbench
=============================

// Module: row_packer
// PURPOSE
//  Output-side counterpart of the column router. It consumes the 8-lane PE result
//  stream (8 x 8-bit results plus a per-lane valid mask, 0xFC on the first row and
//  0xFF otherwise), compacts the valid bytes in lane order, and packs them into 64-bit
//  words. Words leave through a valid/ready stream toward the writeback DMA. It tracks
//  one output row of col_size beats and reports row_done.
// PARAMETERS
//  RowBufSize   256                   max beats per row; must match the router's value
//  RowBufAddrW  $clog2(RowBufSize)    width of col_size
//  FifoDepth    4                     output word FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1    single clock; all logic on the rising edge
//  nrst       in   1    synchronous, active-low reset
//  pack_en    in   1    start a row; sampled only in IDLE
//  col_size   in   RowBufAddrW  beats in this row; 0 is treated as 1
//  res_valid  in   8    per-lane valid; lane i = res_data[8i+7:8i]
//  res_data   in   64   lane results
//  in_ready   out  1    packer can accept a beat this cycle
//  out_valid  out  1    out_data/out_keep/out_last are valid
//  out_ready  in   1    downstream accepts the word when out_valid && out_ready
//  out_data   out  64   packed bytes; byte 0 = oldest
//  out_keep   out  8    byte enables; 0xFF except on a partial last word
//  out_last   out  1    final word of the row
//  row_done   out  1    level; row fully drained
//  overflow   out  1    sticky; a beat arrived while in_ready=0
// BEHAVIOUR
//  - Reset (nrst=0 at the edge): state=IDLE, accumulator and FIFO emptied, beat count 0.
//    Every output is 0. A reset mid-row discards all pending data with no flush.
//  - A beat is any RUN cycle with res_valid!=0. Cycles with an all-zero mask (the
//    router's WAIT cycles) are ignored.
//  - FSM IDLE->RUN->(FLUSH)->DONE->IDLE:
//    - IDLE: on pack_en, latch max=(col_size==0)?1:col_size, clear row_done, clear the
//      count, and go to RUN. While not in IDLE, pack_en is ignored.
//    - RUN: each beat appends popcount(res_valid) bytes, in ascending lane order, to
//      the accumulator and increments the count.
//      - If the accumulator reaches >=8 bytes, push the low 8 as one word
//        (keep=0xFF) and keep the remainder (<=7 bytes).
//      - On the beat where count+1==max:
//        - remainder 0 and a word was pushed: that word has last=1; go to DONE.
//        - otherwise go to FLUSH.
//    - FLUSH: when the FIFO is not full, push the remainder with keep=(1<<n)-1 and
//      last=1, zero-padded. If n==0 and no word was pushed this row, push nothing.
//      Go to DONE.
//    - DONE: when the FIFO is empty and the last word has been accepted, set row_done=1
//      and go to IDLE. row_done holds until the next accepted pack_en.
//  - in_ready = (state==RUN) && (FIFO free entries >= 1). This guarantees a beat
//    never needs more than one push.
//  - A beat with in_ready=0 sets overflow. The beat is dropped and the count is not
//    incremented. overflow clears only on reset.
//  - Latency: a word pushed at edge t is visible on out_valid after edge t; FIFO
//    output is show-ahead.
//  - Simultaneous push and pop on a full FIFO is legal: occupancy is unchanged.
//  - out_data/keep/last are stable while out_valid && !out_ready.
//  - Byte counts use 4-bit arithmetic (max 7+8=15). The beat count is RowBufAddrW+1
//    bits, so max=RowBufSize does not wrap.
// STRUCTURE
//  - Shared package: NUM_LANES=8, LANE_W=8, WORD_W=64, FSM state encodings (2-bit),
//    MASK_FIRST_ROW=8'hFC and MASK_FULL=8'hFF. The router uses the same constants.
//  - One sub-module: sync_fifo (WIDTH=64+8+1, DEPTH=FifoDepth), with show-ahead output
//    and full/empty/count.
//  - Lane compaction (prefix-popcount byte select) stays inline.
// TESTING
//  1. col_size=2, two beats of mask 0xFF with data 0x0706..00, then 0x0F0E..08 ->
//     two words, keep=FF, the second with last=1, row_done=1 after the pop.
//  2. col_size=1, mask 0xFC, data 0x0706050403020100 -> one word 0x0000070605040302,
//     keep=0x3F, last=1.
//  3. col_size=3, masks FC,FF,FF (22 bytes) -> words keep FF, FF, 3F; last only on
//     the third word.
//  4. Hold out_ready=0, col_size=8, all masks FF -> in_ready drops after FifoDepth
//     words; the next beat sets overflow=1. Words are held stable, and data resumes
//     in order when out_ready=1.
//  5. Pull nrst low while in RUN with 3 bytes pending -> all outputs 0 next cycle and
//     no flush word. A new pack_en/col_size=1 works normally.
//  6. col_size=0 with one 0xFF beat -> one word, last=1 (0 treated as 1). pack_en
//     pulsed during RUN is ignored.

Source files
------------

// File: rtl/row_packer_pkg.sv
// Shared constants and types for the PE-result row packer and its router counterpart.
package row_packer_pkg;
  localparam int NUM_LANES = 8;
  localparam int LANE_W    = 8;
  localparam int WORD_W    = NUM_LANES * LANE_W;
  localparam int ENTRY_W   = WORD_W + NUM_LANES + 1;

  localparam logic [7:0] MASK_FIRST_ROW = 8'hFC;
  localparam logic [7:0] MASK_FULL      = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pack_state_e;

  // Byte enables for the lowest n bytes of a word.
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    keep_mask = 8'((16'd1 << n) - 16'd1);
  endfunction
endpackage

// File: rtl/row_packer_if.sv
// Bundle of the PE-result input stream, packed-word output stream and row status.
interface row_packer_if #(
  parameter int RowBufAddrW = 8
);
  import row_packer_pkg::*;

  logic                   pack_en;
  logic [RowBufAddrW-1:0] col_size;
  logic [NUM_LANES-1:0]   res_valid;
  logic [WORD_W-1:0]      res_data;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_W-1:0]      out_data;
  logic [NUM_LANES-1:0]   out_keep;
  logic                   out_last;
  logic                   row_done;
  logic                   overflow;
  pack_state_e            state;

  // Handshakes: a beat transfers on an edge where res_valid!=0 && in_ready; a word
  // transfers on an edge where out_valid && out_ready. Once out_valid is high the
  // word fields hold until taken. state is the packer FSM, exposed for debug.
  modport slave (
    input  pack_en, col_size, res_valid, res_data, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, row_done, overflow, state
  );

  modport master (
    output pack_en, col_size, res_valid, res_data, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, row_done, overflow, state
  );
endinterface

// File: rtl/row_packer_sync_fifo.sv
// Synchronous show-ahead FIFO; the head entry reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [PtrW:0]    cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PtrW+1)'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/row_packer.sv
// Compacts valid PE result bytes in lane order and packs them into 64-bit words
// for the writeback stream, tracking one output row of col_size beats.
module row_packer
  import row_packer_pkg::*;
#(
  parameter int RowBufSize  = 256,
  parameter int RowBufAddrW = $clog2(RowBufSize),
  parameter int FifoDepth   = 4
) (
  input  logic         clk,
  input  logic         nrst,
  row_packer_if.slave  bus
);
  localparam int CntW   = RowBufAddrW + 1;
  localparam int CountW = $clog2(FifoDepth) + 1;

  pack_state_e      state_q, state_d;
  logic [CntW-1:0]  max_q, cnt_q;
  logic [55:0]      acc_q;
  logic [3:0]       acc_n_q;
  logic             row_done_q, overflow_q;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic [CountW-1:0]  fifo_count;

  logic        beat, beat_acc, last_beat, word_full;
  logic [7:0]  merged [16];
  logic [3:0]  pos, total, rem_n;
  logic [55:0] rem;
  logic [63:0] word_lo;

  assign bus.in_ready = (state_q == ST_RUN) && (fifo_count < CountW'(FifoDepth));
  assign beat         = (state_q == ST_RUN) && (bus.res_valid != '0);
  assign beat_acc     = beat && bus.in_ready;
  assign last_beat    = beat_acc && ((cnt_q + CntW'(1)) == max_q);

  // Pending bytes first, then each valid lane at its prefix-popcount slot.
  always_comb begin
    for (int j = 0; j < 16; j++) merged[j] = 8'h00;
    for (int j = 0; j < 7; j++)
      if (4'(j) < acc_n_q) merged[j] = acc_q[8*j +: 8];
    pos = acc_n_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.res_valid[i]) begin
        merged[pos] = bus.res_data[8*i +: 8];
        pos = pos + 4'd1;
      end
    end
    total     = pos;
    word_full = (total >= 4'd8);
    for (int j = 0; j < 8; j++) word_lo[8*j +: 8] = merged[j];
    for (int j = 0; j < 7; j++) rem[8*j +: 8] = word_full ? merged[j+8] : merged[j];
    rem_n = word_full ? (total - 4'd8) : total;
  end

  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    fifo_din  = '0;
    unique case (state_q)
      ST_IDLE: if (bus.pack_en) state_d = ST_RUN;
      ST_RUN: begin
        if (beat_acc) begin
          if (word_full) begin
            fifo_push = 1'b1;
            fifo_din  = {word_lo, 8'hFF, (last_beat && (rem_n == 4'd0))};
          end
          if (last_beat) state_d = (word_full && (rem_n == 4'd0)) ? ST_DONE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!fifo_full) begin
          if (acc_n_q != 4'd0) begin
            fifo_push = 1'b1;
            fifo_din  = {8'h00, acc_q, keep_mask(acc_n_q), 1'b1};
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (fifo_empty) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      max_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      acc_n_q    <= '0;
      row_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (beat && !bus.in_ready) overflow_q <= 1'b1;
      if (state_q == ST_IDLE && bus.pack_en) begin
        max_q      <= (bus.col_size == '0) ? CntW'(1) : {1'b0, bus.col_size};
        cnt_q      <= '0;
        acc_q      <= '0;
        acc_n_q    <= '0;
        row_done_q <= 1'b0;
      end
      if (beat_acc) begin
        cnt_q   <= cnt_q + CntW'(1);
        acc_q   <= rem;
        acc_n_q <= rem_n;
      end
      if (state_q == ST_FLUSH && !fifo_full) begin
        acc_q   <= '0;
        acc_n_q <= '0;
      end
      if (state_q == ST_DONE && fifo_empty) row_done_q <= 1'b1;
    end
  end

  assign fifo_pop = !fifo_empty && bus.out_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FifoDepth)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_dout[ENTRY_W-1 -: WORD_W];
  assign bus.out_keep  = fifo_dout[NUM_LANES:1];
  assign bus.out_last  = fifo_dout[0];
  assign bus.row_done  = row_done_q;
  assign bus.overflow  = overflow_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_row_packer.sv
// Bench for row_packer: directed rows, randomized rows, backpressure and reset.
`timescale 1ns/1ps
module tb_row_packer;
  import row_packer_pkg::*;

  localparam int RowBufSize = 256;
  localparam int AddrW      = 8;
  localparam int FifoDepth  = 4;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 1;  // 0: hold low, 1: always high, 2: random

  logic [ENTRY_W-1:0] exp_q[$];
  logic [ENTRY_W-1:0] got_q[$];
  logic [7:0]         row_mask[$];
  logic [63:0]        row_data[$];

  row_packer_if #(.RowBufAddrW(AddrW)) bus();

  row_packer #(
    .RowBufSize (RowBufSize),
    .FifoDepth  (FifoDepth)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // ---------------- clock / reset / ready driver ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    bus.out_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
  end

  // Word monitor: a transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (nrst && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_data, bus.out_keep, bus.out_last});
  end

  initial begin
    #3ms;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Concatenate every valid byte of every accepted beat, then cut into 8-byte words.
  function automatic void build_expected();
    logic [7:0]  bytes[$];
    logic [63:0] w;
    logic [7:0]  k;
    int n;
    for (int b = 0; b < row_mask.size(); b++)
      for (int l = 0; l < 8; l++)
        if (row_mask[b][l]) bytes.push_back(row_data[b][8*l +: 8]);
    n = bytes.size();
    for (int s = 0; s < n; s += 8) begin
      w = '0;
      k = '0;
      for (int j = 0; j < 8 && s + j < n; j++) begin
        w[8*j +: 8] = bytes[s+j];
        k[j] = 1'b1;
      end
      exp_q.push_back({w, k, (s + 8 >= n)});
    end
    row_mask.delete();
    row_data.delete();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input logic [AddrW-1:0] cs);
    bus.col_size = cs;
    bus.pack_en  = 1'b1;
    tick();
    bus.pack_en  = 1'b0;
  endtask

  task automatic drive_beat(input logic [7:0] m, input logic [63:0] d, output bit accepted);
    accepted = bus.in_ready && (m != 8'h00);
    bus.res_valid = m;
    bus.res_data  = d;
    tick();
    bus.res_valid = '0;
    if (accepted) begin
      row_mask.push_back(m);
      row_data.push_back(d);
    end
  endtask

  task automatic send_beat(input logic [7:0] m, input logic [63:0] d);
    int guard = 0;
    bit acc;
    while (!bus.in_ready && guard < 200) begin
      tick();
      guard++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_beat_in_ready got=%b want=1", bus.in_ready);
    end
    drive_beat(m, d, acc);
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    while (bus.row_done !== 1'b1 && guard < 600) begin
      tick();
      guard++;
    end
    checks++;
    if (bus.row_done !== 1'b1) begin
      errors++;
      $display("FAIL %s row_done got=%b want=1", name, bus.row_done);
    end
  endtask

  task automatic check_words(input string name);
    logic [ENTRY_W-1:0] e, g;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s word_count got=%0d want=%0d", name, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s word got=%h want=%h", name, g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_keep, bus.out_last,
         bus.row_done, bus.overflow} !== '0 || bus.state !== ST_IDLE) begin
      errors++;
      $display("FAIL %s outputs got=%b%b_%h_%h_%b%b%b state=%0d want=all zero, state 0", name,
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_keep, bus.out_last,
               bus.row_done, bus.overflow, bus.state);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_two_full();
    start_row(2);
    checks++;
    if (bus.row_done !== 1'b0) begin
      errors++;
      $display("FAIL two_full row_done_clear got=%b want=0", bus.row_done);
    end
    send_beat(MASK_FULL, 64'h0706050403020100);
    send_beat(MASK_FULL, 64'h0F0E0D0C0B0A0908);
    build_expected();
    wait_done("two_full");
    check_words("two_full");
  endtask

  task automatic test_first_row();
    logic [ENTRY_W-1:0] want;
    want = {64'h0000070605040302, 8'h3F, 1'b1};
    start_row(1);
    send_beat(MASK_FIRST_ROW, 64'h0706050403020100);
    build_expected();
    wait_done("first_row");
    checks++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      errors++;
      $display("FAIL first_row word got=%h (n=%0d) want=%h", (got_q.size() > 0) ? got_q[0] : '0,
               got_q.size(), want);
    end
    check_words("first_row");
  endtask

  task automatic test_three_beats();
    start_row(3);
    send_beat(MASK_FIRST_ROW, rand64());
    send_beat(MASK_FULL, rand64());
    send_beat(MASK_FULL, rand64());
    build_expected();
    wait_done("three_beats");
    check_words("three_beats");
  endtask

  task automatic test_col_zero();
    start_row(0);
    bus.col_size = 8'd5;
    bus.pack_en  = 1'b1;
    tick();
    bus.pack_en  = 1'b0;
    checks++;
    if (bus.state !== ST_RUN) begin
      errors++;
      $display("FAIL col_zero state got=%0d want=%0d", bus.state, ST_RUN);
    end
    send_beat(MASK_FULL, rand64());
    build_expected();
    wait_done("col_zero");
    check_words("col_zero");
  endtask

  task automatic test_random();
    int cs;
    logic [7:0] m;
    rdy_mode = 2;
    for (int r = 0; r < 7; r++) begin
      cs = (r == 6) ? 255 : $urandom_range(1, 6);
      start_row(AddrW'(cs));
      for (int b = 0; b < cs; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        case ($urandom_range(0, 2))
          0:       m = MASK_FIRST_ROW;
          1:       m = MASK_FULL;
          default: m = 8'($urandom_range(1, 255));
        endcase
        send_beat(m, rand64());
      end
      build_expected();
      wait_done("random");
      check_words("random");
      checks++;
      if (bus.overflow !== 1'b0) begin
        errors++;
        $display("FAIL random overflow got=%b want=0", bus.overflow);
      end
    end
    rdy_mode = 1;
    tick();
  endtask

  task automatic test_overflow();
    bit acc;
    logic [ENTRY_W-1:0] head;
    rdy_mode = 0;
    tick();
    start_row(8);
    for (int b = 0; b < FifoDepth; b++) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL overflow in_ready_fill got=%b want=1", bus.in_ready);
      end
      drive_beat(MASK_FULL, rand64(), acc);
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow full got=in_ready %b valid %b ovf %b want=0 1 0",
               bus.in_ready, bus.out_valid, bus.overflow);
    end
    head = {bus.out_data, bus.out_keep, bus.out_last};
    drive_beat(MASK_FULL, rand64(), acc);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow sticky got=%b want=1", bus.overflow);
    end
    repeat (2) tick();
    checks++;
    if ({bus.out_data, bus.out_keep, bus.out_last} !== head) begin
      errors++;
      $display("FAIL overflow hold got=%h want=%h", {bus.out_data, bus.out_keep, bus.out_last}, head);
    end
    rdy_mode = 1;
    for (int b = 0; b < 4; b++) send_beat(MASK_FULL, rand64());
    build_expected();
    wait_done("overflow");
    check_words("overflow");
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow kept got=%b want=1", bus.overflow);
    end
  endtask

  task automatic test_reset_mid_row();
    start_row(4);
    send_beat(8'h07, rand64());
    row_mask.delete();
    row_data.delete();
    nrst = 1'b0;
    tick();
    check_all_zero("reset_mid_row");
    nrst = 1'b1;
    repeat (4) tick();
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_row flush_words got=%0d want=0", got_q.size());
    end
    got_q.delete();
    start_row(1);
    send_beat(MASK_FULL, rand64());
    build_expected();
    wait_done("after_reset");
    check_words("after_reset");
  endtask

  initial begin
    bus.pack_en   = 1'b0;
    bus.col_size  = '0;
    bus.res_valid = '0;
    bus.res_data  = '0;
    test_reset();
    test_two_full();
    test_first_row();
    test_three_beats();
    test_col_zero();
    test_random();
    test_overflow();
    test_reset_mid_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
